m31_sbox_arbiter: RTL and testbench

M31_SBOX_ARBITER -- requirements
Module: m31_sbox_arbiter

---
 rtl/m31_sbox_arbiter.sv | 102 ++++++++++
 tb/tb_m31_sbox_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/m31_sbox_arbiter.sv
// rtl/m31_sbox_arbiter.sv - round-robin arbiter sharing one x^5 mod (2^31-1) S-box pipeline
module m31_sbox_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int SBOX_LAT = 15
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   input  logic [NUM_REQ-1:0][30:0]           req_data_i,
   output logic [NUM_REQ-1:0]                 req_ready_o,
   output logic [30:0]                        sbox_in_o,
   input  logic [30:0]                        sbox_out_i,
   output logic [NUM_REQ-1:0]                 rsp_valid_o,
   output logic [30:0]                        rsp_data_o,
   output logic [$clog2(SBOX_LAT+1)-1:0]      inflight_o,
   output logic                               busy_o
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(SBOX_LAT+1);

   logic [IW-1:0]       last_grant;
   logic [IW-1:0]       grant_idx;
   logic [IW-1:0]       cand;
   logic                grant_any;
   int                  sum;

   logic [SBOX_LAT-1:0] tag_v;
   logic [IW-1:0]       tag_idx [SBOX_LAT];
   logic                rsp_fire;

   // Round-robin search starting one past the last winner; nothing is granted while in reset
   always_comb begin
      req_ready_o = '0;
      grant_idx   = '0;
      grant_any   = 1'b0;
      cand        = '0;
      sum         = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         sum = int'(last_grant) + off;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         cand = IW'(sum);
         if (rst_n && !grant_any && req_valid_i[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant_any) req_ready_o[grant_idx] = 1'b1;
   end

   // Winning operand goes straight to the S-box in the grant cycle
   always_comb begin
      sbox_in_o = grant_any ? req_data_i[grant_idx] : 31'h0;
   end

   // Tag pipeline tracks which requester owns each S-box stage; shifts every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         for (int i = 0; i < SBOX_LAT; i++) tag_idx[i] <= '0;
      end else begin
         tag_v[0]   <= grant_any;
         tag_idx[0] <= grant_idx;
         for (int i = 1; i < SBOX_LAT; i++) begin
            tag_v[i]   <= tag_v[i-1];
            tag_idx[i] <= tag_idx[i-1];
         end
      end
   end

   assign rsp_fire = tag_v[SBOX_LAT-1];

   // Route the S-box result to the owner of the oldest tag; zero when that tag is empty
   always_comb begin
      rsp_valid_o = '0;
      rsp_data_o  = 31'h0;
      if (rsp_fire) begin
         rsp_valid_o[tag_idx[SBOX_LAT-1]] = 1'b1;
         rsp_data_o                       = sbox_out_i;
      end
   end

   // Arbitration pointer and in-flight count; simultaneous issue and response leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= IW'(NUM_REQ - 1);
         inflight_o <= '0;
      end else begin
         if (grant_any) last_grant <= grant_idx;
         if (grant_any && !rsp_fire && inflight_o != CW'(SBOX_LAT))
            inflight_o <= inflight_o + CW'(1);
         else if (!grant_any && rsp_fire && inflight_o != '0)
            inflight_o <= inflight_o - CW'(1);
      end
   end

   // Busy while anything is queued at the inputs or still inside the S-box
   always_comb begin
      busy_o = (inflight_o != '0) || (|req_valid_i);
   end

endmodule

// File: tb/tb_m31_sbox_arbiter.sv
// tb/tb_m31_sbox_arbiter.sv - scoreboard bench for the S-box arbiter
module tb_m31_sbox_arbiter;

   localparam int N   = 4;
   localparam int LAT = 15;
   localparam logic [30:0] P = 31'h7FFFFFFF;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       req_valid;
   logic [N-1:0][30:0] req_data;
   logic [N-1:0]       ready;
   logic [30:0]        sbox_in;
   logic [30:0]        sbox_out;
   logic [N-1:0]       rsp_valid;
   logic [30:0]        rsp_data;
   logic [3:0]         inflight;
   logic               busy;

   typedef struct {
      int          idx;
      logic [30:0] data;
      int          due;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cycle    = 0;
   int   m_last   = N - 1;

   logic [30:0] pipe [LAT];

   m31_sbox_arbiter #(.NUM_REQ(N), .SBOX_LAT(LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (ready),
      .sbox_in_o   (sbox_in),
      .sbox_out_i  (sbox_out),
      .rsp_valid_o (rsp_valid),
      .rsp_data_o  (rsp_data),
      .inflight_o  (inflight),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [30:0] pow5(input logic [30:0] x);
      logic [63:0] a;
      a = (64'(x) * 64'(x)) % 64'(P);
      a = (a * a) % 64'(P);
      a = (a * 64'(x)) % 64'(P);
      return a[30:0];
   endfunction

   // Reference S-box: fixed-latency pipeline, not reset, keeps emitting through reset
   always @(posedge clk) begin
      pipe[0] <= pow5(sbox_in);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign sbox_out = pipe[LAT-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      int          eidx;
      int          s;
      logic [N-1:0] eoh;
      logic [N-1:0] roh;
      logic [30:0] edata;
      exp_t        e;
      @(negedge clk);
      eidx = -1;
      for (int off = 1; off <= N; off++) begin
         s = (m_last + off) % N;
         if (eidx < 0 && req_valid[s]) eidx = s;
      end
      eoh   = '0;
      edata = '0;
      if (eidx >= 0) begin
         eoh[eidx] = 1'b1;
         edata     = req_data[eidx];
      end
      chk("req_ready", ready, eoh);
      chk("sbox_in", sbox_in, edata);
      chk("inflight", inflight, q.size());
      chk("busy", busy, (q.size() != 0 || req_valid != '0));
      if (q.size() > 0 && q[0].due == cycle) begin
         e   = q.pop_front();
         roh = '0;
         roh[e.idx] = 1'b1;
         chk("rsp_valid", rsp_valid, roh);
         chk("rsp_data", rsp_data, e.data);
      end else begin
         chk("rsp_valid_idle", rsp_valid, 0);
         chk("rsp_data_idle", rsp_data, 0);
      end
      if (eidx >= 0) begin
         e.idx  = eidx;
         e.data = pow5(edata);
         e.due  = cycle + LAT;
         q.push_back(e);
         m_last = eidx;
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) req_data[i] = 31'($urandom % 32'h7FFFFFFF);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock
   task automatic do_reset();
      req_valid = '1;
      rst_n     = 1'b0;
      #2;
      chk("rst_ready", ready, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete();
      m_last = N - 1;
      cycle++;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      #12;
      chk("init_ready", ready, 0);
      chk("init_rsp_valid", rsp_valid, 0);
      chk("init_rsp_data", rsp_data, 0);
      chk("init_inflight", inflight, 0);
      chk("init_busy", busy, 0);
      req_valid = '1;
      #1;
      chk("init_ready_masked", ready, 0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single operand from requester 0: 2^5 = 32
      req_valid   = 4'b0001;
      req_data[0] = 31'd2;
      cyc();
      idle(20);

      // -1 and 0 edge operands
      req_valid   = 4'b0100;
      req_data[2] = P - 31'd1;
      cyc();
      req_valid   = 4'b0010;
      req_data[1] = 31'd0;
      cyc();
      idle(17);

      // move pointer to 3, then alternate between requesters 1 and 3
      req_valid = 4'b1000;
      rand_data();
      cyc();
      req_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         cyc();
      end
      idle(16);

      // full load from reset: saturation and steady-state issue/response
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 40; i++) begin
         rand_data();
         cyc();
      end
      idle(17);

      // reset with operands in flight: none of them may come back
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         rand_data();
         cyc();
      end
      idle(2);
      do_reset();
      idle(20);

      chk("sb_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
